// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg : shared constants for the seven-segment VGA renderer              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package seg7_pkg;

    localparam int c_seg_a = 0;
    localparam int c_seg_b = 1;
    localparam int c_seg_c = 2;
    localparam int c_seg_d = 3;
    localparam int c_seg_e = 4;
    localparam int c_seg_f = 5;
    localparam int c_seg_g = 6;

    // Entry v holds the lit segments of BCD value v, bit 0 = a ... bit 6 = g
    localparam logic [15:0][6:0] c_seg7_lut = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int seg7_pitch(input int digit_w, input int gap);
        return digit_w + gap;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_cell_hit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_cell_hit : range compare and cell-local coordinates for one digit     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module seg7_cell_hit #(
    parameter int X0 = 16,
    parameter int Y0 = 120,
    parameter int W  = 48,
    parameter int H  = 96
) (
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    output logic       o_hit,
    output logic [9:0] o_lx,
    output logic [8:0] o_ly
);

    localparam logic [10:0] c_x_lo = 11'(X0);
    localparam logic [10:0] c_x_hi = 11'(X0 + W);
    localparam logic [9:0]  c_y_lo = 10'(Y0);
    localparam logic [9:0]  c_y_hi = 10'(Y0 + H);

    assign o_hit = ({1'b0, i_x} >= c_x_lo) && ({1'b0, i_x} < c_x_hi) &&
                   ({1'b0, i_y} >= c_y_lo) && ({1'b0, i_y} < c_y_hi);
    assign o_lx  = i_x - c_x_lo[9:0];
    assign o_ly  = i_y - c_y_lo[8:0];

endmodule
`default_nettype wire

// File: rtl/seg7_vga_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_vga_renderer : BCD digits and colon separators drawn on 640x480 VGA   |
// | Option SEG7_SEP_BLINK_EN : separators blink every BLINK_FRAMES frames      |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module seg7_vga_renderer
    import seg7_pkg::*;
#(
    parameter int                    NUM_DIGITS   = 8,
    parameter int                    ORIGIN_X     = 16,
    parameter int                    ORIGIN_Y     = 120,
    parameter int                    DIGIT_W      = 48,
    parameter int                    DIGIT_H      = 96,
    parameter int                    SEG_T        = 8,
    parameter int                    GAP          = 24,
    parameter logic [NUM_DIGITS-1:0] SEP_MASK     = 8'b0001_0100,
    parameter int                    BLINK_FRAMES = 30
) (
    input  logic                    CLK,
    input  logic                    RST_BTN,
    input  logic                    i_pix_stb,
    input  logic [9:0]              i_x,
    input  logic [8:0]              i_y,
    input  logic                    i_frame_start,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    output logic                    o_seg_on,
    output logic                    o_sep_on,
    output logic [3:0]              VGA_R,
    output logic [3:0]              VGA_G,
    output logic [3:0]              VGA_B
);

    localparam int c_pitch = seg7_pitch(DIGIT_W, GAP);
    localparam int c_mid   = (DIGIT_H - SEG_T) / 2;
    localparam int c_dot1  = ORIGIN_Y + DIGIT_H / 3;
    localparam int c_dot2  = ORIGIN_Y + (2 * DIGIT_H) / 3;

    localparam logic [9:0] c_lx_t  = 10'(SEG_T);
    localparam logic [9:0] c_lx_r  = 10'(DIGIT_W - SEG_T);
    localparam logic [9:0] c_lx_w  = 10'(DIGIT_W);
    localparam logic [8:0] c_ly_t  = 9'(SEG_T);
    localparam logic [8:0] c_ly_m  = 9'(c_mid);
    localparam logic [8:0] c_ly_mt = 9'(c_mid + SEG_T);
    localparam logic [8:0] c_ly_b  = 9'(DIGIT_H - SEG_T);
    localparam logic [8:0] c_ly_h  = 9'(DIGIT_H);

    logic [4*NUM_DIGITS-1:0] r_snap;
    logic                    r_armed;
    logic                    w_sep_vis;

    logic [NUM_DIGITS-1:0]   w_hit;
    logic [NUM_DIGITS-1:0]   w_sep;
    logic [9:0]              w_cell_lx [NUM_DIGITS];
    logic [8:0]              w_cell_ly [NUM_DIGITS];
    logic [3:0]              w_val;
    logic [9:0]              w_lx;
    logic [8:0]              w_ly;

    logic                    r_s1_hit;
    logic                    r_s1_sep;
    logic [3:0]              r_s1_val;
    logic [9:0]              r_s1_lx;
    logic [8:0]              r_s1_ly;

    logic [6:0]              w_lit;
    logic                    w_seg_on;
    logic                    r_seg_on;
    logic                    r_sep_on;
    logic [3:0]              r_red;

    // r_armed keeps the display dark after reset until a real snapshot lands
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_snap  <= '1;
            r_armed <= 1'b0;
        end else if (i_frame_start) begin
            r_snap  <= i_digits;
            r_armed <= 1'b1;
        end
    end

`ifdef SEG7_SEP_BLINK_EN
    localparam int c_cnt_w = $clog2(BLINK_FRAMES + 1);

    logic [c_cnt_w-1:0] r_frame_cnt;
    logic               r_blink_phase;

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (i_frame_start) begin
            if (r_frame_cnt == c_cnt_w'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_sep_vis = r_armed & ~r_blink_phase;
`else
    assign w_sep_vis = r_armed;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_cell
        seg7_cell_hit #(
            .X0 (ORIGIN_X + k * c_pitch),
            .Y0 (ORIGIN_Y),
            .W  (DIGIT_W),
            .H  (DIGIT_H)
        ) u_cell_hit (
            .i_x   (i_x),
            .i_y   (i_y),
            .o_hit (w_hit[k]),
            .o_lx  (w_cell_lx[k]),
            .o_ly  (w_cell_ly[k])
        );

        if (SEP_MASK[k]) begin : g_sep
            localparam int c_cx = ORIGIN_X + k * c_pitch + DIGIT_W + GAP / 2;
            logic w_dx, w_dy1, w_dy2;
            assign w_dx  = ({1'b0, i_x} >= 11'(c_cx - SEG_T / 2)) && ({1'b0, i_x} < 11'(c_cx + SEG_T / 2));
            assign w_dy1 = ({1'b0, i_y} >= 10'(c_dot1 - SEG_T / 2)) && ({1'b0, i_y} < 10'(c_dot1 + SEG_T / 2));
            assign w_dy2 = ({1'b0, i_y} >= 10'(c_dot2 - SEG_T / 2)) && ({1'b0, i_y} < 10'(c_dot2 + SEG_T / 2));
            assign w_sep[k] = w_dx & (w_dy1 | w_dy2);
        end else begin : g_no_sep
            assign w_sep[k] = 1'b0;
        end
    end

    // Cells never overlap, so at most one hit bit is set and an OR-select suffices
    always_comb begin
        w_val = '0;
        w_lx  = '0;
        w_ly  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_val = w_val | (r_snap[4*k +: 4] & {4{w_hit[k]}});
            w_lx  = w_lx  | (w_cell_lx[k]     & {10{w_hit[k]}});
            w_ly  = w_ly  | (w_cell_ly[k]     & {9{w_hit[k]}});
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_s1_hit <= 1'b0;
            r_s1_sep <= 1'b0;
            r_s1_val <= '0;
            r_s1_lx  <= '0;
            r_s1_ly  <= '0;
        end else if (i_pix_stb) begin
            r_s1_hit <= |w_hit;
            r_s1_sep <= (|w_sep) & w_sep_vis;
            r_s1_val <= w_val;
            r_s1_lx  <= w_lx;
            r_s1_ly  <= w_ly;
        end
    end

    always_comb begin
        w_lit          = '0;
        w_lit[c_seg_a] = (r_s1_lx >= c_lx_t) && (r_s1_lx < c_lx_r) && (r_s1_ly < c_ly_t);
        w_lit[c_seg_g] = (r_s1_lx >= c_lx_t) && (r_s1_lx < c_lx_r) && (r_s1_ly >= c_ly_m) && (r_s1_ly < c_ly_mt);
        w_lit[c_seg_d] = (r_s1_lx >= c_lx_t) && (r_s1_lx < c_lx_r) && (r_s1_ly >= c_ly_b) && (r_s1_ly < c_ly_h);
        w_lit[c_seg_f] = (r_s1_lx < c_lx_t) && (r_s1_ly >= c_ly_t) && (r_s1_ly < c_ly_m);
        w_lit[c_seg_b] = (r_s1_lx >= c_lx_r) && (r_s1_lx < c_lx_w) && (r_s1_ly >= c_ly_t) && (r_s1_ly < c_ly_m);
        w_lit[c_seg_e] = (r_s1_lx < c_lx_t) && (r_s1_ly >= c_ly_mt) && (r_s1_ly < c_ly_b);
        w_lit[c_seg_c] = (r_s1_lx >= c_lx_r) && (r_s1_lx < c_lx_w) && (r_s1_ly >= c_ly_mt) && (r_s1_ly < c_ly_b);
        w_seg_on       = r_s1_hit & (|(w_lit & c_seg7_lut[r_s1_val]));
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_seg_on <= 1'b0;
            r_sep_on <= 1'b0;
            r_red    <= '0;
        end else if (i_pix_stb) begin
            r_seg_on <= w_seg_on;
            r_sep_on <= r_s1_sep;
            r_red    <= {4{w_seg_on | r_s1_sep}};
        end
    end

    assign o_seg_on = r_seg_on;
    assign o_sep_on = r_sep_on;
    assign VGA_R    = r_red;
    assign VGA_G    = 4'h0;
    assign VGA_B    = 4'h0;

endmodule
`default_nettype wire
